elevator_ctrl: RTL and testbench
================================

Name: elevator_ctrl

Overview:
- Main elevator car controller FSM.
- Latches hall/car call requests and drives the motor direction outputs from a floor-arrival sensor.
- Holds the door open by pulsing KT to the existing `timer` block and waiting for its T output.
- Sits directly upstream of `timer`: it produces KT and consumes T.

Parameters:
- NUM_FLOORS, 4, number of served floors (2..16).
- FLOOR_W, 2, width of the floor index; must satisfy 2**FLOOR_W >= NUM_FLOORS.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_FLOORS  call request; a one-cycle pulse on bit i requests floor i.
- floor_tick  input  1  one-cycle pulse from the shaft sensor when the car reaches the next floor in the current direction.
- door_reopen  input  1  door-reopen button; level, sampled every cycle.
- T  input  1  timeout from `timer`.
- KT  output  1  timer kick; one-cycle pulse.
- move_up  output  1  motor up command.
- move_down  output  1  motor down command.
- door_open  output  1  door actuator command.
- cur_floor  output  FLOOR_W  current car floor.
- pending  output  NUM_FLOORS  latched outstanding requests.

Behaviour:
- Reset (async, immediate): state=IDLE, dir=UP, cur_floor=0, pending=0, KT=0, move_up=0, move_down=0, door_open=0.
- All outputs are registered.
- move_up and move_down are never both 1.
- door_open=1 only in DOOR_OPEN; move_* are 0 in DOOR_OPEN.
- Request latching:
  - pending[i] is set on req[i].
  - Out-of-range bits are ignored.
  - pending[cur_floor] is cleared in the same edge that enters or re-kicks DOOR_OPEN at that floor.
  - A set and a clear of the same bit on the same edge: clear wins, because the door is serving that floor.
- Derived signals (combinational):
  - above = any pending bit with index > cur_floor.
  - below = any pending bit with index < cur_floor.
  - here = (req | pending)[cur_floor].
- States:
  - IDLE
    - If here: go to DOOR_OPEN and pulse KT.
    - Else if above and (dir=UP or !below): go to MOVE_UP with dir=UP.
    - Else if below: go to MOVE_DOWN with dir=DOWN.
    - Else: stay in IDLE.
  - MOVE_UP
    - On floor_tick: cur_floor+1.
    - If the new floor is pending, or no request remains above it: go to DOOR_OPEN if pending, otherwise IDLE.
    - Otherwise keep moving.
  - MOVE_DOWN: symmetric to MOVE_UP with cur_floor-1.
  - DOOR_OPEN
    - If here or door_reopen: pulse KT again (restarts the timer), clear pending[cur_floor], stay in DOOR_OPEN.
    - Else if T: apply the IDLE direction rule (excluding here), going to MOVE_UP, MOVE_DOWN or IDLE; door_open drops on the same edge.
    - The reopen/here case has priority over a simultaneous T.
- Latency:
  - floor_tick sampled at edge n updates cur_floor, move_*, door_open and KT at edge n, visible in cycle n+1.
  - KT is high for exactly that one cycle.
- Stopping at a floor:
  - The car stops at an intermediate floor only if it is pending at arrival.
  - A req for the current floor arriving the same cycle as floor_tick counts as pending.
- Ignored inputs:
  - floor_tick is ignored in IDLE and DOOR_OPEN.
  - floor_tick in MOVE_UP at cur_floor=NUM_FLOORS-1 is ignored, with no wrap; the same applies in MOVE_DOWN at 0.
  - T is ignored outside DOOR_OPEN.
  - T is also ignored in the cycle KT is high, so a stale T from a previous period cannot close the door.
- Reset mid-operation:
  - Any state returns to IDLE at floor 0 with pending cleared; the motor and door drop immediately.
  - The car position is re-synchronised by system homing, which is outside this block.

Decomposition:
- Shared package (elevator_pkg):
  - State encoding constants IDLE=2'd0, MOVE_UP=2'd1, MOVE_DOWN=2'd2, DOOR_OPEN=2'd3.
  - Direction constants DIR_UP=1'b1, DIR_DOWN=1'b0.
  - Default NUM_FLOORS.
- One sub-module, request_register:
  - Contains the pending flops with set/clear logic.
  - Contains the above/below/here reductions relative to cur_floor.
- The FSM, cur_floor counter and output registers stay in elevator_ctrl.

Test Plan:
1. Reset, then req=4'b0001 at floor 0 in IDLE -> next cycle door_open=1, KT=1 for one cycle, pending=0; T pulse 10 cycles later -> door_open=0, state IDLE.
2. Idle at floor 0, req=4'b1000 -> move_up=1; three floor_tick pulses -> cur_floor 1,2,3, then move_up=0, door_open=1, KT pulse, pending=0.
3. Moving up from 0 toward 3, req=4'b0100 injected before the second tick -> car stops at 2 (door cycle, T), then resumes move_up to 3.
4. Car at 2 going up, pending floors 3 and 0 -> serves 3 first, then on T goes move_down, ticks to 0; dir=DOWN.
5. In DOOR_OPEN, door_reopen=1 in the same cycle as T=1 -> door stays open, a new KT pulse is issued, state is unchanged; a later T alone closes the door.
6. Reset asserted mid-MOVE_DOWN at floor 2 -> move_down=0, cur_floor=0, pending=0 immediately (asynchronously); floor_tick during reset has no effect.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car controller.
package elevator_pkg;

  localparam int DEF_NUM_FLOORS = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elevator_ctrl_request_register.sv
// Outstanding call requests plus above/below/here reductions against the car floor.
module request_register
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic                  clr,
  input  logic [FLOOR_W-1:0]    clr_floor,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  above,
  output logic                  below,
  output logic                  here
);

  logic [NUM_FLOORS-1:0] pending_q, pending_d;

  // Clear is applied after the set so a served floor cannot re-latch on the same edge.
  always_comb begin
    pending_d = pending_q | req;
    above     = 1'b0;
    below     = 1'b0;
    here      = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (clr && (i == int'(clr_floor))) pending_d[i] = 1'b0;
      if (i > int'(cur_floor)) above = above | pending_q[i];
      if (i < int'(cur_floor)) below = below | pending_q[i];
      if (i == int'(cur_floor)) here = req[i] | pending_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/elevator_ctrl.sv
// Elevator car controller: call servicing, motor direction and door hold via the external timer.
// state     | meaning
// IDLE      | parked, door closed, no motion
// MOVE_UP   | motor up, counting floor_tick upward
// MOVE_DOWN | motor down, counting floor_tick downward
// DOOR_OPEN | door held open until T with no reopen
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic                  floor_tick,
  input  logic                  door_reopen,
  input  logic                  T,
  output logic                  KT,
  output logic                  move_up,
  output logic                  move_down,
  output logic                  door_open,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  state_e             state_q, state_d;
  logic               dir_q, dir_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic               kt_q, kt_d;
  logic               up_q, up_d;
  logic               dn_q, dn_d;
  logic               door_q, door_d;

  logic               clr;
  logic [FLOOR_W-1:0] clr_floor;
  logic               above, below, here;

  logic [FLOOR_W-1:0] tgt;
  logic               tgt_pend, tgt_more_up, tgt_more_dn;
  state_e             go_state;
  logic               go_dir;

  request_register #(
    .NUM_FLOORS(NUM_FLOORS),
    .FLOOR_W   (FLOOR_W)
  ) u_req (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .clr      (clr),
    .clr_floor(clr_floor),
    .cur_floor(floor_q),
    .pending  (pending),
    .above    (above),
    .below    (below),
    .here     (here)
  );

  // Arrival floor view; a request landing with the tick counts as pending there.
  always_comb begin
    tgt         = (state_q == MOVE_DOWN) ? floor_q - FLOOR_W'(1) : floor_q + FLOOR_W'(1);
    tgt_pend    = 1'b0;
    tgt_more_up = 1'b0;
    tgt_more_dn = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i == int'(tgt)) tgt_pend = pending[i] | req[i];
      if (i > int'(tgt))  tgt_more_up = tgt_more_up | pending[i] | req[i];
      if (i < int'(tgt))  tgt_more_dn = tgt_more_dn | pending[i] | req[i];
    end
  end

  always_comb begin
    go_state = IDLE;
    go_dir   = dir_q;
    if (above && (dir_q == DIR_UP || !below)) begin
      go_state = MOVE_UP;
      go_dir   = DIR_UP;
    end else if (below) begin
      go_state = MOVE_DOWN;
      go_dir   = DIR_DOWN;
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    floor_d   = floor_q;
    kt_d      = 1'b0;
    clr       = 1'b0;
    clr_floor = floor_q;
    case (state_q)
      IDLE: begin
        if (here) begin
          state_d = DOOR_OPEN;
          kt_d    = 1'b1;
          clr     = 1'b1;
        end else begin
          state_d = go_state;
          dir_d   = go_dir;
        end
      end
      MOVE_UP: begin
        if (floor_tick && floor_q != TOP_FLOOR) begin
          floor_d = tgt;
          if (tgt_pend) begin
            state_d   = DOOR_OPEN;
            kt_d      = 1'b1;
            clr       = 1'b1;
            clr_floor = tgt;
          end else if (!tgt_more_up) begin
            state_d = IDLE;
          end
        end
      end
      MOVE_DOWN: begin
        if (floor_tick && floor_q != '0) begin
          floor_d = tgt;
          if (tgt_pend) begin
            state_d   = DOOR_OPEN;
            kt_d      = 1'b1;
            clr       = 1'b1;
            clr_floor = tgt;
          end else if (!tgt_more_dn) begin
            state_d = IDLE;
          end
        end
      end
      DOOR_OPEN: begin
        // kt_q masks a T left over from the previous timer period.
        if (here || door_reopen) begin
          kt_d = 1'b1;
          clr  = 1'b1;
        end else if (T && !kt_q) begin
          state_d = go_state;
          dir_d   = go_dir;
        end
      end
      default: state_d = IDLE;
    endcase
    up_d   = (state_d == MOVE_UP);
    dn_d   = (state_d == MOVE_DOWN);
    door_d = (state_d == DOOR_OPEN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= DIR_UP;
      floor_q <= '0;
      kt_q    <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      door_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      floor_q <= floor_d;
      kt_q    <= kt_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      door_q  <= door_d;
    end
  end

  assign KT        = kt_q;
  assign move_up   = up_q;
  assign move_down = dn_q;
  assign door_open = door_q;
  assign cur_floor = floor_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl: expected outputs queued per stimulus cycle, popped after the edge.
module tb_elevator_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic       floor_tick = 1'b0;
  logic       door_reopen = 1'b0;
  logic       T = 1'b0;
  logic       KT, move_up, move_down, door_open;
  logic [1:0] cur_floor;
  logic [3:0] pending;

  int tests = 0;
  int failed = 0;

  typedef struct packed {
    logic       kt;
    logic       up;
    logic       dn;
    logic       door;
    logic [1:0] fl;
    logic [3:0] pd;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  elevator_ctrl #(.NUM_FLOORS(4), .FLOOR_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .floor_tick (floor_tick),
    .door_reopen(door_reopen),
    .T          (T),
    .KT         (KT),
    .move_up    (move_up),
    .move_down  (move_down),
    .door_open  (door_open),
    .cur_floor  (cur_floor),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic push_exp(input string tag, input logic e_kt, input logic e_up, input logic e_dn,
                          input logic e_door, input logic [1:0] e_fl, input logic [3:0] e_pd);
    exp_t e;
    e.kt = e_kt; e.up = e_up; e.dn = e_dn; e.door = e_door; e.fl = e_fl; e.pd = e_pd;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'(1), 32'(0));
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk({t, ".KT"},        32'(KT),        32'(e.kt));
      chk({t, ".move_up"},   32'(move_up),   32'(e.up));
      chk({t, ".move_down"}, 32'(move_down), 32'(e.dn));
      chk({t, ".door_open"}, 32'(door_open), 32'(e.door));
      chk({t, ".cur_floor"}, 32'(cur_floor), 32'(e.fl));
      chk({t, ".pending"},   32'(pending),   32'(e.pd));
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the next edge, then check them.
  task automatic cyc(input string tag, input logic [3:0] r, input logic ft, input logic ro, input logic t,
                     input logic e_kt, input logic e_up, input logic e_dn, input logic e_door,
                     input logic [1:0] e_fl, input logic [3:0] e_pd);
    req = r; floor_tick = ft; door_reopen = ro; T = t;
    push_exp(tag, e_kt, e_up, e_dn, e_door, e_fl, e_pd);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    req = '0; floor_tick = 1'b0; door_reopen = 1'b0; T = 1'b0;
    #1;
    push_exp(tag, 0, 0, 0, 0, 2'd0, 4'b0000);
    pop_check();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    do_reset("t1_reset");

    // 1: call at the current floor opens the door at once
    cyc("t1_req",  4'b0001, 0, 0, 0,  1, 0, 0, 1, 2'd0, 4'b0000);
    for (int i = 0; i < 8; i++)
      cyc("t1_wait", 4'b0000, 0, 0, 0,  0, 0, 0, 1, 2'd0, 4'b0000);
    cyc("t1_T",    4'b0000, 0, 0, 1,  0, 0, 0, 0, 2'd0, 4'b0000);
    cyc("t1_tick_idle", 4'b0000, 1, 0, 0,  0, 0, 0, 0, 2'd0, 4'b0000);

    // 2: run to the top floor
    cyc("t2_req",  4'b1000, 0, 0, 0,  0, 0, 0, 0, 2'd0, 4'b1000);
    cyc("t2_go",   4'b0000, 0, 0, 0,  0, 1, 0, 0, 2'd0, 4'b1000);
    cyc("t2_f1",   4'b0000, 1, 0, 0,  0, 1, 0, 0, 2'd1, 4'b1000);
    cyc("t2_f2",   4'b0000, 1, 0, 0,  0, 1, 0, 0, 2'd2, 4'b1000);
    cyc("t2_f3",   4'b0000, 1, 0, 0,  1, 0, 0, 1, 2'd3, 4'b0000);
    cyc("t2_staleT", 4'b0000, 0, 0, 1, 0, 0, 0, 1, 2'd3, 4'b0000);
    cyc("t2_T",    4'b0000, 0, 0, 1,  0, 0, 0, 0, 2'd3, 4'b0000);

    // 3: intermediate stop picked up while moving
    do_reset("t3_reset");
    cyc("t3_req",  4'b1000, 0, 0, 0,  0, 0, 0, 0, 2'd0, 4'b1000);
    cyc("t3_go",   4'b0000, 0, 0, 0,  0, 1, 0, 0, 2'd0, 4'b1000);
    cyc("t3_f1",   4'b0000, 1, 0, 0,  0, 1, 0, 0, 2'd1, 4'b1000);
    cyc("t3_req2", 4'b0100, 0, 0, 0,  0, 1, 0, 0, 2'd1, 4'b1100);
    cyc("t3_f2",   4'b0000, 1, 0, 0,  1, 0, 0, 1, 2'd2, 4'b1000);
    cyc("t3_hold", 4'b0000, 0, 0, 0,  0, 0, 0, 1, 2'd2, 4'b1000);
    cyc("t3_T",    4'b0000, 0, 0, 1,  0, 1, 0, 0, 2'd2, 4'b1000);
    cyc("t3_f3",   4'b0000, 1, 0, 0,  1, 0, 0, 1, 2'd3, 4'b0000);
    cyc("t3_hold2", 4'b0000, 0, 0, 0, 0, 0, 0, 1, 2'd3, 4'b0000);
    cyc("t3_T2",   4'b0000, 0, 0, 1,  0, 0, 0, 0, 2'd3, 4'b0000);

    // 4: serve up first, then reverse to the bottom
    do_reset("t4_reset");
    cyc("t4_req",  4'b0100, 0, 0, 0,  0, 0, 0, 0, 2'd0, 4'b0100);
    cyc("t4_go",   4'b0000, 0, 0, 0,  0, 1, 0, 0, 2'd0, 4'b0100);
    cyc("t4_f1",   4'b0000, 1, 0, 0,  0, 1, 0, 0, 2'd1, 4'b0100);
    cyc("t4_f2",   4'b0000, 1, 0, 0,  1, 0, 0, 1, 2'd2, 4'b0000);
    cyc("t4_req2", 4'b1001, 0, 0, 0,  0, 0, 0, 1, 2'd2, 4'b1001);
    cyc("t4_tick_door", 4'b0000, 1, 0, 0, 0, 0, 0, 1, 2'd2, 4'b1001);
    cyc("t4_T",    4'b0000, 0, 0, 1,  0, 1, 0, 0, 2'd2, 4'b1001);
    cyc("t4_f3",   4'b0000, 1, 0, 0,  1, 0, 0, 1, 2'd3, 4'b0001);
    cyc("t4_hold", 4'b0000, 0, 0, 0,  0, 0, 0, 1, 2'd3, 4'b0001);
    cyc("t4_T2",   4'b0000, 0, 0, 1,  0, 0, 1, 0, 2'd3, 4'b0001);
    cyc("t4_d2",   4'b0000, 1, 0, 0,  0, 0, 1, 0, 2'd2, 4'b0001);
    cyc("t4_d1",   4'b0000, 1, 0, 0,  0, 0, 1, 0, 2'd1, 4'b0001);
    cyc("t4_d0",   4'b0000, 1, 0, 0,  1, 0, 0, 1, 2'd0, 4'b0000);
    cyc("t4_hold2", 4'b0000, 0, 0, 0, 0, 0, 0, 1, 2'd0, 4'b0000);
    cyc("t4_T3",   4'b0000, 0, 0, 1,  0, 0, 0, 0, 2'd0, 4'b0000);

    // 5: reopen beats a simultaneous T; same-floor call re-kicks the timer
    do_reset("t5_reset");
    cyc("t5_req",    4'b0001, 0, 0, 0,  1, 0, 0, 1, 2'd0, 4'b0000);
    cyc("t5_hold",   4'b0000, 0, 0, 0,  0, 0, 0, 1, 2'd0, 4'b0000);
    cyc("t5_reopenT", 4'b0000, 0, 1, 1, 1, 0, 0, 1, 2'd0, 4'b0000);
    cyc("t5_staleT", 4'b0000, 0, 0, 1,  0, 0, 0, 1, 2'd0, 4'b0000);
    cyc("t5_here",   4'b0001, 0, 0, 0,  1, 0, 0, 1, 2'd0, 4'b0000);
    cyc("t5_hold2",  4'b0000, 0, 0, 0,  0, 0, 0, 1, 2'd0, 4'b0000);
    cyc("t5_reopen", 4'b0000, 0, 1, 0,  1, 0, 0, 1, 2'd0, 4'b0000);
    cyc("t5_hold3",  4'b0000, 0, 0, 0,  0, 0, 0, 1, 2'd0, 4'b0000);
    cyc("t5_T",      4'b0000, 0, 0, 1,  0, 0, 0, 0, 2'd0, 4'b0000);

    // 6: asynchronous reset while moving down at floor 2
    do_reset("t6_reset");
    cyc("t6_req",  4'b1000, 0, 0, 0,  0, 0, 0, 0, 2'd0, 4'b1000);
    cyc("t6_go",   4'b0000, 0, 0, 0,  0, 1, 0, 0, 2'd0, 4'b1000);
    cyc("t6_f1",   4'b0000, 1, 0, 0,  0, 1, 0, 0, 2'd1, 4'b1000);
    cyc("t6_f2",   4'b0000, 1, 0, 0,  0, 1, 0, 0, 2'd2, 4'b1000);
    cyc("t6_f3",   4'b0000, 1, 0, 0,  1, 0, 0, 1, 2'd3, 4'b0000);
    cyc("t6_req2", 4'b0001, 0, 0, 0,  0, 0, 0, 1, 2'd3, 4'b0001);
    cyc("t6_T",    4'b0000, 0, 0, 1,  0, 0, 1, 0, 2'd3, 4'b0001);
    cyc("t6_d2",   4'b0000, 1, 0, 0,  0, 0, 1, 0, 2'd2, 4'b0001);
    #2;
    reset = 1'b1;
    floor_tick = 1'b1;
    #1;
    push_exp("t6_async", 0, 0, 0, 0, 2'd0, 4'b0000);
    pop_check();
    @(posedge clk);
    #1;
    push_exp("t6_held", 0, 0, 0, 0, 2'd0, 4'b0000);
    pop_check();
    reset = 1'b0;
    cyc("t6_after", 4'b0000, 0, 0, 0,  0, 0, 0, 0, 2'd0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
